// File: rtl/regs_wb_arbiter_pkg.sv
// regs_wb_arbiter_pkg: requester indices, register-address type and default starvation limit
package regs_wb_arbiter_pkg;
    typedef logic [4:0] reg_addr_t;
    localparam logic [1:0] REQ_WB  = 2'd0;
    localparam logic [1:0] REQ_MDU = 2'd1;
    localparam logic [1:0] REQ_DBG = 2'd2;
    localparam int STARVE_LIMIT_DEF = 8;
endpackage

// File: rtl/regs_scoreboard.sv
// regs_scoreboard: pending-write busy mask with set-wins-over-clear and two read lookups
module regs_scoreboard
    import regs_wb_arbiter_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      rsv_valid,
    input  reg_addr_t rsv_addr,
    input  logic      clr_valid,
    input  reg_addr_t clr_addr,
    input  reg_addr_t rd_addr_A,
    input  reg_addr_t rd_addr_B,
    output logic      busy_A,
    output logic      busy_B
);
    logic [31:0] mask, set_v, clr_v;
    always_comb begin
        set_v = rsv_valid ? ((32'd1 << rsv_addr) & ~32'd1) : '0;
        clr_v = clr_valid ? (32'd1 << clr_addr) : '0;
    end
    always_ff @(posedge clk or posedge rst)
        if (rst) mask <= '0;
        else     mask <= (mask & ~clr_v) | set_v;
    assign busy_A = mask[rd_addr_A];
    assign busy_B = mask[rd_addr_B];
endmodule

// File: rtl/regs_wb_arbiter.sv
// regs_wb_arbiter: shares the register-file write port among wb, MDU and debug; tracks MDU reservations.
// Define REGS_WB_FWD_EN to add write-through forwarding ports fwd_A/fwd_B.
module regs_wb_arbiter
    import regs_wb_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    input  reg_addr_t   wb_addr,
    input  logic [31:0] wb_data,
    input  logic        mdu_valid,
    input  reg_addr_t   mdu_addr,
    input  logic [31:0] mdu_data,
    output logic        mdu_ready,
    input  logic        dbg_valid,
    input  reg_addr_t   dbg_addr,
    input  logic [31:0] dbg_data,
    output logic        dbg_ready,
    output logic        stall_pipe,
    input  logic        rsv_valid,
    input  reg_addr_t   rsv_addr,
    input  reg_addr_t   rd_addr_A,
    input  reg_addr_t   rd_addr_B,
    output logic        busy_A,
    output logic        busy_B,
    output logic        reg_we,
    output reg_addr_t   reg_W_addr,
    output logic [31:0] wdata
`ifdef REGS_WB_FWD_EN
    ,
    input  logic [31:0] rdata_A,
    input  logic [31:0] rdata_B,
    output logic [31:0] fwd_A,
    output logic [31:0] fwd_B
`endif
);
    logic [7:0]  cnt;
    logic        rr_mdu, out_mdu, gnt_v;
    logic [1:0]  gnt;
    reg_addr_t   g_addr;
    logic [31:0] g_data;
    always_comb begin
        gnt_v  = !rst && (wb_valid || mdu_valid || dbg_valid);
        gnt    = wb_valid ? REQ_WB : (mdu_valid && (rr_mdu || !dbg_valid)) ? REQ_MDU : REQ_DBG;
        g_addr = gnt == REQ_WB ? wb_addr : gnt == REQ_MDU ? mdu_addr : dbg_addr;
        g_data = gnt == REQ_WB ? wb_data : gnt == REQ_MDU ? mdu_data : dbg_data;
    end
    assign mdu_ready  = gnt_v && gnt == REQ_MDU;
    assign dbg_ready  = gnt_v && gnt == REQ_DBG;
    assign stall_pipe = cnt == 8'(STARVE_LIMIT);
    // counter holds at the limit if wb ignores the stall, keeping stall_pipe raised
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt        <= '0;
            rr_mdu     <= 1'b1;
            out_mdu    <= 1'b0;
            reg_we     <= 1'b0;
            reg_W_addr <= '0;
            wdata      <= '0;
        end else begin
            cnt     <= (wb_valid && (mdu_valid || dbg_valid)) ? (stall_pipe ? cnt : cnt + 8'd1) : '0;
            reg_we  <= gnt_v && g_addr != '0;
            out_mdu <= mdu_ready;
            if (mdu_ready || dbg_ready) rr_mdu <= dbg_ready;
            if (gnt_v) begin
                reg_W_addr <= g_addr;
                wdata      <= g_data;
            end
        end
    regs_scoreboard u_sb (
        .clk       (clk),
        .rst       (rst),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .clr_valid (reg_we && out_mdu),
        .clr_addr  (reg_W_addr),
        .rd_addr_A (rd_addr_A),
        .rd_addr_B (rd_addr_B),
        .busy_A    (busy_A),
        .busy_B    (busy_B)
    );
`ifdef REGS_WB_FWD_EN
    assign fwd_A = (reg_we && reg_W_addr == rd_addr_A) ? wdata : rdata_A;
    assign fwd_B = (reg_we && reg_W_addr == rd_addr_B) ? wdata : rdata_B;
`endif
endmodule

// File: doc/regs_wb_arbiter.md
# regs_wb_arbiter

Write-port arbiter and pending-write scoreboard for the CPU's 32×32 register file (two read ports, one write port, r0 hardwired zero). It shares the single write port among three requesters: pipeline writeback, the multicycle multiply/divide unit (MDU), and the debug port. It also tracks which registers have an outstanding long-latency write so the hazard unit can stall dependent reads. It sits between the WB stage / MDU / debug bridge and the register file's write inputs.

## Interface
- STARVE_LIMIT, 8: consecutive cycles a pending MDU/debug request may be blocked by pipeline writeback before the pipeline is stalled for it (range 1..255).
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- wb_valid, wb_addr, wb_data  in  1/5/32  pipeline writeback request; has no ready and is never refused.
- mdu_valid, mdu_addr, mdu_data  in  1/5/32  MDU result request.
- mdu_ready  out  1  MDU request accepted this cycle.
- dbg_valid, dbg_addr, dbg_data  in  1/5/32  debug write request.
- dbg_ready  out  1  debug request accepted this cycle.
- stall_pipe  out  1  pipeline must hold; no wb_valid may be presented next cycle.
- rsv_valid, rsv_addr  in  1/5  issue stage reserves a destination for an MDU op.
- rd_addr_A, rd_addr_B  in  5  current register-file read addresses.
- busy_A, busy_B  out  1  read address has an outstanding reservation.
- reg_we, reg_W_addr, wdata  out  1/5/32  register-file write port, registered.

## Operation
- Arbitration is combinational on the request inputs. The winner is captured into the output register at the posedge.
- Priority: wb > (mdu, dbg round-robin). The RR pointer toggles to the other requester after each mdu/dbg grant. After reset the pointer favours mdu.
- mdu_ready / dbg_ready are asserted only in the cycle that requester wins. A requester holds valid/addr/data stable until ready.
- Starvation counter: increments each cycle wb_valid=1 while mdu_valid|dbg_valid=1, and clears otherwise.
  - When it reaches STARVE_LIMIT, stall_pipe asserts for exactly one cycle.
  - During that stall cycle wb_valid is guaranteed 0, so the RR winner is granted and the counter clears.
- wb_valid=1 during a stall_pipe cycle is a protocol error. wb still wins; the counter saturates at STARVE_LIMIT.
- Addr 0 requests are granted normally (ready asserted), but the output stage drives reg_we=0.
- Scoreboard: a 32-bit busy mask; bit 0 is constant 0.
  - rsv_valid with rsv_addr≠0 sets the bit at the next edge.
  - A granted mdu write clears its bit at the edge where reg_we is high.
  - Set and clear of the same bit at the same edge: set wins.
  - wb and dbg writes never touch the mask.
- busy_A = mask[rd_addr_A], busy_B = mask[rd_addr_B], both combinational.

## Timing
- Write latency is 1 cycle. A grant in cycle N drives reg_we/reg_W_addr/wdata during N+1, and the register file captures at the end of N+1.
- Throughput is one write per cycle. Back-to-back grants produce back-to-back reg_we.
- Busy clear coincides with the register-file capture edge, so a read in N+2 sees the new value with busy=0.
- Reset values: reg_we=0, reg_W_addr=0, wdata=0, mdu_ready=0, dbg_ready=0, stall_pipe=0, mask=0, counter=0, RR→mdu.
- Reset asserted mid-operation drops the pending output write and all reservations. A requester holding valid through reset is re-arbitrated from the reset state.

## Configuration
- REGS_WB_FWD_EN defined: adds inputs rdata_A/rdata_B (32) and outputs fwd_A/fwd_B (32).
  - fwd_X = wdata when reg_we=1 and reg_W_addr==rd_addr_X (≠0); otherwise fwd_X = rdata_X.
  - This gives write-through forwarding in cycle N+1.
- Undefined: no forwarding ports and no extra logic. Consumers wait one cycle after the write.

## Structure
- Shared package holds the requester-index constants (REQ_WB=0, REQ_MDU=1, REQ_DBG=2), the 5-bit register-address typedef, and the default STARVE_LIMIT.
- One sub-module, regs_scoreboard, holds the busy mask, set/clear logic and the two read lookups. Arbiter, starvation counter and output register stay in the top level.

## Test plan
- Only mdu_valid, addr 5, data 0xDEADBEEF: mdu_ready the same cycle; next cycle reg_we=1, reg_W_addr=5, wdata=0xDEADBEEF.
- mdu and dbg valid together, no wb, for 4 cycles: grants alternate mdu, dbg, mdu, dbg.
- wb_valid held continuously with mdu pending and STARVE_LIMIT=8: stall_pipe is high in exactly the 9th cycle, mdu is granted then, and the counter restarts.
- rsv_valid addr 7, then mdu write addr 7 three cycles later: busy_A (rd_addr_A=7) is high from the cycle after the reserve through the write cycle, and 0 after.
- dbg write to addr 0: dbg_ready=1, reg_we stays 0, mask unchanged. A rsv to addr 0 leaves busy at 0.
- Assert rst during the cycle after a grant: reg_we drops to 0 immediately, mask and counter clear, and no write occurs.
